bubble_sort_ctrl: RTL and testbench
===================================

Name: bubble_sort_ctrl

Overview:
FSM controller that sequences the bubble-sort datapath: loads n_1, runs nested i/j loops, reads adjacent RAM words into Reg_a/Reg_b, compares them via the ALU and writes them back swapped when out of order. Host owns the RAM while idle. Drives every datapath control input and consumes ALU compare flags. Sits between the top level and DATAPATH.

Parameters:
ADDR_W, 16, width of i/j/k/address path (matches datapath N)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins sort when idle
host_mem_en  in  1  host RAM enable, forwarded while idle
host_rw  in  1  host RAM direction (1 = write), forwarded while idle
in_1_gt_in_2, in_1_lt_in_2, in_1_eq_in_2  in  1 each  ALU compare flags
busy  out  1  high in every state except IDLE
mem_en, RW_MEM  out  1 each  RAM enable / direction (1 = write)
ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1  out  1 each  register loads
clear_eoc, preset_eoc  out  1 each  EOC flag control
sel_m3, sel_m5, sel_m6, sel_m7, sel_m8  out  1 each  2:1 mux selects
sel_m1, sel_m2, sel_m4  out  2 each  4:1 mux selects
ALU_sel  out  2  00 ADD, 01 SUB, 10 CMP (flags only), 11 PASS in_1

Behaviour:
- Reset: state IDLE; all outputs 0 except forwarded host signals.
- Mux codes: m1 {0 i, 1 j, 2 a, 3 k}; m2 {0 n_1, 1 b, 2 all-ones, 3 zero}; m4 {0 i, 1 j, 2 k, 3 zero}; m3 {0 a, 1 b}; m5/m6 {0 zero, 1 ALU}; m7 {0 data_in, 1 m3}; m8 {0 addr_ptr, 1 m4}.
- All states one cycle; Moore outputs; unlisted outputs 0.
- IDLE: sel_m7=0, sel_m8=0, mem_en=host_mem_en, RW_MEM=host_rw. start -> INIT with clear_eoc=1 in the same cycle.
- INIT: ld_n_1, ld_i with sel_m5=0. -> I_CHK.
- I_CHK: CMP i vs n_1 (m1=0, m2=0). lt -> J_INIT, else DONE.
- J_INIT: ld_j, sel_m6=0. -> J_CHK.
- J_CHK: CMP j vs n_1 (m1=1, m2=0). lt -> K_CALC, else I_INC.
- K_CALC: k = j - (-1): SUB, m1=1, m2=2, ld_k. -> RD_A.
- RD_A: mem_en, read, m8=1, m4=1. -> LD_A (ld_a; RAM read data valid one cycle after address).
- RD_B: read, m4=2. -> LD_B (ld_b). -> CMP.
- CMP: CMP, m1=2, m2=1. gt -> WR_A, else J_INC.
- WR_A: write b to mem[j]: mem_en, RW_MEM=1, m7=1, m3=1, m8=1, m4=1. -> WR_B: write a to mem[k]: m3=0, m4=2. -> J_INC.
- J_INC: j = j+1 (SUB, m1=1, m2=2, m6=1, ld_j). -> J_CHK.
- I_INC: i = i+1 (m1=0, m2=2, SUB, m5=1, ld_i). -> I_CHK.
- DONE: preset_eoc=1. -> IDLE. eoc_out stays 1 until next start.
- start while busy ignored. Host signals ignored while busy. rst mid-sort returns to IDLE immediately; RAM contents undefined.
- Equal elements never swapped (stable sort).

Optional Feature:
EARLY_EXIT_EN: internal swapped flag, cleared in J_INIT, set in WR_A. In I_INC, flag clear -> DONE instead of I_CHK. Without the macro, always N-1 full passes. Output timing is otherwise identical.

Test Plan:
- Reset mid-sort (assert rst in RD_B) -> busy=0, all load/enable outputs 0 asynchronously; next start sorts normally.
- Host loads 16 words descending 15..0, pulses start -> eoc=1 on the cycle after DONE; host readback 0..15 ascending.
- Already-sorted 0..15 without macro -> busy high exactly 1863 cycles, no RW_MEM=1 while busy.
- Same input with EARLY_EXIT_EN -> busy high exactly 126 cycles; memory unchanged.
- Duplicates {5,3,5,3,...} -> result 3,3,...,5,5; no write issued when a==b.
- start pulsed while busy -> ignored, cycle count unchanged; host_mem_en toggled while busy -> mem_en follows FSM only.

Source files
------------

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl: sequencing FSM for the bubble-sort datapath.
// It owns every datapath control input and consumes the ALU compare flags.
// While idle the host drives the RAM through the forwarded enable/direction.
// While busy the controller walks the nested i/j loops. Each inner step
// reads mem[j] and mem[j+1] into Reg_a/Reg_b, compares them, and writes
// them back swapped when they are out of order.
// Optional build macro: EARLY_EXIT_EN. When it is defined, the sort stops
// after the first pass that makes no swap. When it is undefined, the sort
// always runs N-1 full passes.
module bubble_sort_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       host_mem_en,
    input  logic       host_rw,
    input  logic       in_1_gt_in_2,
    input  logic       in_1_lt_in_2,
    input  logic       in_1_eq_in_2,
    output logic       busy,
    output logic       mem_en,
    output logic       RW_MEM,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_i,
    output logic       ld_j,
    output logic       ld_k,
    output logic       ld_n_1,
    output logic       clear_eoc,
    output logic       preset_eoc,
    output logic       sel_m3,
    output logic       sel_m5,
    output logic       sel_m6,
    output logic       sel_m7,
    output logic       sel_m8,
    output logic [1:0] sel_m1,
    output logic [1:0] sel_m2,
    output logic [1:0] sel_m4,
    output logic [1:0] ALU_sel
);

    // ALU operation codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_CMP  = 2'b10;

    // Mux codes used below
    localparam logic [1:0] M1_I     = 2'd0;
    localparam logic [1:0] M1_J     = 2'd1;
    localparam logic [1:0] M1_A     = 2'd2;
    localparam logic [1:0] M2_N_1   = 2'd0;
    localparam logic [1:0] M2_B     = 2'd1;
    localparam logic [1:0] M2_ONES  = 2'd2;
    localparam logic [1:0] M4_J     = 2'd1;
    localparam logic [1:0] M4_K     = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        I_CHK,
        J_INIT,
        J_CHK,
        K_CALC,
        RD_A,
        LD_A,
        RD_B,
        LD_B,
        CMP,
        WR_A,
        WR_B,
        J_INC,
        I_INC,
        DONE
    } state_t;

    state_t state_q, state_d;

    // The equality flag and the address width belong to the datapath contract.
    // Swaps only need gt and loop tests only need lt; equal words fall through
    // the "not greater" path, which keeps the sort stable.
    logic [ADDR_W:0] unused_contract;
    assign unused_contract = {in_1_eq_in_2, {ADDR_W{1'b0}}};

`ifdef EARLY_EXIT_EN
    logic swapped_q, swapped_d;

    // Remembers whether the current outer pass performed any swap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swapped_q <= 1'b0;
        end else begin
            swapped_q <= swapped_d;
        end
    end
`endif

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs (IDLE also forwards the host RAM controls)
    always_comb begin
        state_d    = state_q;
`ifdef EARLY_EXIT_EN
        swapped_d  = swapped_q;
`endif
        busy       = 1'b1;
        mem_en     = 1'b0;
        RW_MEM     = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_i       = 1'b0;
        ld_j       = 1'b0;
        ld_k       = 1'b0;
        ld_n_1     = 1'b0;
        clear_eoc  = 1'b0;
        preset_eoc = 1'b0;
        sel_m3     = 1'b0;
        sel_m5     = 1'b0;
        sel_m6     = 1'b0;
        sel_m7     = 1'b0;
        sel_m8     = 1'b0;
        sel_m1     = 2'd0;
        sel_m2     = 2'd0;
        sel_m4     = 2'd0;
        ALU_sel    = ALU_ADD;

        unique case (state_q)
            IDLE: begin
                // Host owns the RAM: address from addr_ptr, data from data_in
                busy   = 1'b0;
                mem_en = host_mem_en;
                RW_MEM = host_rw;
                if (start) begin
                    clear_eoc = 1'b1;
                    state_d   = INIT;
                end
            end

            INIT: begin
                // n_1 from the datapath, i cleared through m5
                ld_n_1  = 1'b1;
                ld_i    = 1'b1;
                state_d = I_CHK;
            end

            I_CHK: begin
                ALU_sel = ALU_CMP;
                sel_m1  = M1_I;
                sel_m2  = M2_N_1;
                state_d = in_1_lt_in_2 ? J_INIT : DONE;
            end

            J_INIT: begin
                ld_j    = 1'b1;
`ifdef EARLY_EXIT_EN
                swapped_d = 1'b0;
`endif
                state_d = J_CHK;
            end

            J_CHK: begin
                ALU_sel = ALU_CMP;
                sel_m1  = M1_J;
                sel_m2  = M2_N_1;
                state_d = in_1_lt_in_2 ? K_CALC : I_INC;
            end

            K_CALC: begin
                // k = j - (-1) = j + 1
                ALU_sel = ALU_SUB;
                sel_m1  = M1_J;
                sel_m2  = M2_ONES;
                ld_k    = 1'b1;
                state_d = RD_A;
            end

            RD_A: begin
                mem_en  = 1'b1;
                sel_m8  = 1'b1;
                sel_m4  = M4_J;
                state_d = LD_A;
            end

            LD_A: begin
                // RAM output is registered, so mem[j] is valid now
                ld_a    = 1'b1;
                state_d = RD_B;
            end

            RD_B: begin
                mem_en  = 1'b1;
                sel_m8  = 1'b1;
                sel_m4  = M4_K;
                state_d = LD_B;
            end

            LD_B: begin
                ld_b    = 1'b1;
                state_d = CMP;
            end

            CMP: begin
                ALU_sel = ALU_CMP;
                sel_m1  = M1_A;
                sel_m2  = M2_B;
                state_d = in_1_gt_in_2 ? WR_A : J_INC;
            end

            WR_A: begin
                // mem[j] <= b
                mem_en  = 1'b1;
                RW_MEM  = 1'b1;
                sel_m7  = 1'b1;
                sel_m3  = 1'b1;
                sel_m8  = 1'b1;
                sel_m4  = M4_J;
`ifdef EARLY_EXIT_EN
                swapped_d = 1'b1;
`endif
                state_d = WR_B;
            end

            WR_B: begin
                // mem[k] <= a
                mem_en  = 1'b1;
                RW_MEM  = 1'b1;
                sel_m7  = 1'b1;
                sel_m3  = 1'b0;
                sel_m8  = 1'b1;
                sel_m4  = M4_K;
                state_d = J_INC;
            end

            J_INC: begin
                ALU_sel = ALU_SUB;
                sel_m1  = M1_J;
                sel_m2  = M2_ONES;
                sel_m6  = 1'b1;
                ld_j    = 1'b1;
                state_d = J_CHK;
            end

            I_INC: begin
                ALU_sel = ALU_SUB;
                sel_m1  = M1_I;
                sel_m2  = M2_ONES;
                sel_m5  = 1'b1;
                ld_i    = 1'b1;
`ifdef EARLY_EXIT_EN
                state_d = swapped_q ? I_CHK : DONE;
`else
                state_d = I_CHK;
`endif
            end

            DONE: begin
                preset_eoc = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl. The bench wraps the controller in a
// behavioural datapath: registers, ALU, muxes, a synchronous RAM and an
// EOC flag. A reference bubble sort computes the expected sorted data,
// busy cycles, reads and writes.
module tb_bubble_sort_ctrl;

    localparam int N     = 16;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       host_mem_en;
    logic       host_rw;
    logic       gt, lt, eq;
    logic       busy, mem_en, RW_MEM;
    logic       ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1, clear_eoc, preset_eoc;
    logic       sel_m3, sel_m5, sel_m6, sel_m7, sel_m8;
    logic [1:0] sel_m1, sel_m2, sel_m4, ALU_sel;

    logic [15:0] host_addr, host_din;

    always #5 clk = ~clk;

    bubble_sort_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .host_mem_en(host_mem_en), .host_rw(host_rw),
        .in_1_gt_in_2(gt), .in_1_lt_in_2(lt), .in_1_eq_in_2(eq),
        .busy(busy), .mem_en(mem_en), .RW_MEM(RW_MEM),
        .ld_a(ld_a), .ld_b(ld_b), .ld_i(ld_i), .ld_j(ld_j), .ld_k(ld_k),
        .ld_n_1(ld_n_1), .clear_eoc(clear_eoc), .preset_eoc(preset_eoc),
        .sel_m3(sel_m3), .sel_m5(sel_m5), .sel_m6(sel_m6), .sel_m7(sel_m7),
        .sel_m8(sel_m8), .sel_m1(sel_m1), .sel_m2(sel_m2), .sel_m4(sel_m4),
        .ALU_sel(ALU_sel)
    );

    // Behavioural datapath
    logic [15:0] mem [N];
    logic [15:0] dout, ra, rb, ri, rj, rk, rn1;
    logic        eoc;
    logic [15:0] in1, in2, alu, m4v, addr, wdata;

    always_comb begin
        case (sel_m1)
            2'd0: in1 = ri;
            2'd1: in1 = rj;
            2'd2: in1 = ra;
            default: in1 = rk;
        endcase
        case (sel_m2)
            2'd0: in2 = rn1;
            2'd1: in2 = rb;
            2'd2: in2 = 16'hFFFF;
            default: in2 = 16'h0000;
        endcase
        case (ALU_sel)
            2'd0: alu = in1 + in2;
            2'd1: alu = in1 - in2;
            2'd2: alu = 16'h0000;
            default: alu = in1;
        endcase
        case (sel_m4)
            2'd0: m4v = ri;
            2'd1: m4v = rj;
            2'd2: m4v = rk;
            default: m4v = 16'h0000;
        endcase
        addr  = sel_m8 ? m4v : host_addr;
        wdata = sel_m7 ? (sel_m3 ? rb : ra) : host_din;
    end

    assign gt = (in1 > in2);
    assign lt = (in1 < in2);
    assign eq = (in1 == in2);

    always @(posedge clk) begin
        if (mem_en) begin
            if (RW_MEM) mem[addr[3:0]] <= wdata;
            else        dout <= mem[addr[3:0]];
        end
        if (ld_n_1) rn1 <= 16'(N - 1);
        if (ld_i)   ri  <= sel_m5 ? alu : 16'h0000;
        if (ld_j)   rj  <= sel_m6 ? alu : 16'h0000;
        if (ld_k)   rk  <= alu;
        if (ld_a)   ra  <= dout;
        if (ld_b)   rb  <= dout;
        if (rst)             eoc <= 1'b0;
        else if (clear_eoc)  eoc <= 1'b0;
        else if (preset_eoc) eoc <= 1'b1;
    end

    // Free-running activity counters, sampled mid-cycle
    int busy_total = 0, wr_total = 0, rd_total = 0;
    always @(negedge clk) begin
        if (busy) begin
            busy_total <= busy_total + 1;
            if (mem_en &&  RW_MEM) wr_total <= wr_total + 1;
            if (mem_en && !RW_MEM) rd_total <= rd_total + 1;
        end
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model
    logic [15:0] init_data [N];
    logic [15:0] exp_data  [N];
    int exp_cycles, exp_writes, exp_reads;

    task automatic build_model();
        logic [15:0] arr [N];
        logic [15:0] t;
        int  swaps;
        bit  stop;
        arr = init_data;
        exp_cycles = 1;                 // INIT
        exp_writes = 0;
        exp_reads  = 0;
        stop = 1'b0;
        for (int p = 0; p < N - 1 && !stop; p++) begin
            swaps = 0;
            exp_cycles += 2;            // pass test + inner-loop init
            for (int q = 0; q < N - 1; q++) begin
                exp_cycles += 8;        // test, k, two reads, two loads, compare, j++
                exp_reads  += 2;
                if (arr[q] > arr[q+1]) begin
                    t = arr[q]; arr[q] = arr[q+1]; arr[q+1] = t;
                    swaps++;
                    exp_cycles += 2;
                    exp_writes += 2;
                end
            end
            exp_cycles += 2;            // inner exit test + i++
`ifdef EARLY_EXIT_EN
            if (swaps == 0) stop = 1'b1;
`endif
        end
        if (!stop) exp_cycles += 1;     // final outer test
        exp_cycles += 1;                // DONE
        exp_data = arr;
    endtask

    task automatic host_write(input int a, input logic [15:0] d);
        @(negedge clk);
        host_mem_en = 1'b1; host_rw = 1'b1; host_addr = 16'(a); host_din = d;
        @(negedge clk);
        host_mem_en = 1'b0; host_rw = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [15:0] d);
        @(negedge clk);
        host_mem_en = 1'b1; host_rw = 1'b0; host_addr = 16'(a);
        @(negedge clk);
        host_mem_en = 1'b0;
        d = dout;
    endtask

    task automatic load_mem();
        for (int k = 0; k < N; k++) host_write(k, init_data[k]);
    endtask

    task automatic verify_mem(input string tag);
        logic [15:0] d;
        for (int k = 0; k < N; k++) begin
            host_read(k, d);
            check($sformatf("%s_word%0d", tag, k), 32'(d), 32'(exp_data[k]));
        end
    endtask

    task automatic run_sort(input string tag, input bit disturb);
        int b0, w0, r0, guard;
        b0 = busy_total; w0 = wr_total; r0 = rd_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_eoc_cleared"}, 32'(eoc), 32'd0);
        guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (!busy || guard >= LIMIT) break;
            if (disturb) begin
                start       = (guard == 20);
                host_mem_en = 1'($urandom_range(0, 1));
                host_rw     = 1'b1;
                host_addr   = 16'($urandom_range(0, N - 1));
                host_din    = 16'($urandom);
            end
        end
        start = 1'b0; host_mem_en = 1'b0; host_rw = 1'b0;
        check({tag, "_finished"}, 32'(guard < LIMIT), 32'd1);
        check({tag, "_eoc_set"}, 32'(eoc), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_total - b0), 32'(exp_cycles));
        check({tag, "_writes"}, 32'(wr_total - w0), 32'(exp_writes));
        check({tag, "_reads"}, 32'(rd_total - r0), 32'(exp_reads));
    endtask

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; host_mem_en = 1'b0; host_rw = 1'b0;
        host_addr = 16'h0; host_din = 16'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem", 32'({mem_en, RW_MEM}), 32'd0);
        check("rst_loads", 32'({ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1, clear_eoc, preset_eoc}), 32'd0);
        check("rst_sels", 32'({sel_m3, sel_m5, sel_m6, sel_m7, sel_m8, sel_m1, sel_m2, sel_m4, ALU_sel}), 32'd0);
        host_mem_en = 1'b1; host_rw = 1'b1;
        #1;
        check("idle_forward", 32'({mem_en, RW_MEM}), 32'd3);
        host_mem_en = 1'b0; host_rw = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Descending 15..0
        for (int k = 0; k < N; k++) init_data[k] = 16'(N - 1 - k);
        build_model(); load_mem(); run_sort("desc", 1'b0); verify_mem("desc");

        // Already sorted
        for (int k = 0; k < N; k++) init_data[k] = 16'(k);
        build_model(); load_mem(); run_sort("sorted", 1'b0); verify_mem("sorted");
`ifdef EARLY_EXIT_EN
        check("sorted_cycles_fixed", 32'(exp_cycles), 32'd126);
`else
        check("sorted_cycles_fixed", 32'(exp_cycles), 32'd1863);
`endif

        // Duplicates 5,3,5,3,...
        for (int k = 0; k < N; k++) init_data[k] = (k % 2 == 0) ? 16'd5 : 16'd3;
        build_model(); load_mem(); run_sort("dups", 1'b0); verify_mem("dups");

        // Random data with start and host activity while busy
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) init_data[k] = 16'($urandom_range(0, 31));
            build_model(); load_mem();
            run_sort($sformatf("rand%0d", r), 1'b1);
            verify_mem($sformatf("rand%0d", r));
        end

        // Reset while reading mem[k]
        for (int k = 0; k < N; k++) init_data[k] = 16'($urandom);
        load_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (!(mem_en && !RW_MEM && sel_m8 && sel_m4 == 2'd2) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rdb_reached", 32'(guard < 200), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem", 32'({mem_en, RW_MEM}), 32'd0);
        check("midrst_loads", 32'({ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1, clear_eoc, preset_eoc}), 32'd0);
        check("midrst_sels", 32'({sel_m3, sel_m5, sel_m6, sel_m7, sel_m8, sel_m1, sel_m2, sel_m4, ALU_sel}), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < N; k++) init_data[k] = 16'($urandom_range(0, 1000));
        build_model(); load_mem(); run_sort("after_rst", 1'b0); verify_mem("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
